// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter handing one external memory-mapped bus
// to one of two masters at a time, one beat per grant, with a slave-ready
// handshake and a wait-state timeout that completes the transfer with error.
module bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr_rd,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr_rd,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        bus_cs,
    output logic        bus_wr_rd,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter value seen in the last ACCESS cycle before the timeout fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        favour;     // 0: master 0 wins a tie, 1: master 1 wins
    logic        owner;      // master that holds the current transfer
    logic [7:0]  wait_cnt;

    logic        grant_m1;
    logic        xfer_end;
    logic        xfer_err;
    logic [31:0] end_rdata;

    // Arbitration and end-of-access decode; ready beats a coincident timeout.
    always_comb begin
        grant_m1  = m1_req && (!m0_req || favour);
        xfer_end  = bus_rdy || (wait_cnt == WAIT_LAST);
        xfer_err  = !bus_rdy;
        end_rdata = bus_rdy ? bus_rdata : 32'h0;
    end

    // Transfer sequencer: grant in IDLE, drive the bus in ACCESS, acknowledge in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            favour    <= 1'b0;
            owner     <= 1'b0;
            wait_cnt  <= 8'h0;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= 32'h0;
            bus_cs    <= 1'b0;
            bus_wr_rd <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner     <= grant_m1;
                        favour    <= !grant_m1;
                        wait_cnt  <= 8'h0;
                        bus_cs    <= 1'b1;
                        bus_wr_rd <= grant_m1 ? m1_wr_rd : m0_wr_rd;
                        bus_addr  <= grant_m1 ? m1_addr  : m0_addr;
                        bus_wdata <= grant_m1 ? m1_wdata : m0_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (xfer_end) begin
                        if (owner) begin
                            m1_ack <= 1'b1;
                            m1_err <= xfer_err;
                            if (!bus_wr_rd) m1_rdata <= end_rdata;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= xfer_err;
                            if (!bus_wr_rd) m0_rdata <= end_rdata;
                        end
                        bus_cs    <= 1'b0;
                        bus_wr_rd <= 1'b0;
                        bus_addr  <= 32'h0;
                        bus_wdata <= 32'h0;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus randomized single
// transfers, checked against a transaction-level model of the arbiter.
module tb_bus_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wr;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] bus_rdata;
    logic        bus_rdy;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_cs, bus_wr_rd;
    logic [31:0] bus_addr, bus_wdata;

    int errors = 0;
    int checks = 0;

    // Reference model state: who wins a tie, and each master's rdata.
    int          favour_m;
    logic [31:0] exp_rdata [2];

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_wr_rd(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_wr_rd(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bus_cs(bus_cs), .bus_wr_rd(bus_wr_rd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] mst(input int m);
        return (m == 1) ? {m1_ack, m1_err, m1_rdata} : {m0_ack, m0_err, m0_rdata};
    endfunction

    function automatic logic [133:0] all_outs();
        return {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
                bus_cs, bus_wr_rd, bus_addr, bus_wdata};
    endfunction

    // One lone-master transfer; rdy first high after nwait low ACCESS cycles.
    // Starts and ends in an IDLE cycle.
    task automatic run_xfer(input int m, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rv, input int nwait);
        int          o = 1 - m;
        int          dn;
        logic        exp_err;
        logic [33:0] got, want;
        req[m]   = 1'b1;
        wr[m]    = w;
        addr[m]  = a;
        wdata[m] = d;
        bus_rdy  = 1'b0;
        bus_rdata = rv;
        favour_m = o;
        exp_err  = (nwait >= TO);
        dn = (nwait < TO) ? nwait + 2 : TO + 1;
        tick;
        // Changes after grant must not reach the bus.
        addr[m]  = ~a;
        wdata[m] = ~d;
        wr[m]    = ~w;
        for (int k = 1; k < dn; k++) begin
            checks++;
            if ({bus_cs, bus_wr_rd, bus_addr, bus_wdata, m0_ack, m1_ack} !== {1'b1, w, a, d, 2'b00}) begin
                errors++;
                $display("FAIL access_bus m%0d cyc%0d: got cs=%b wr=%b a=%h d=%h ack=%b%b want cs=1 wr=%b a=%h d=%h ack=00",
                         m, k, bus_cs, bus_wr_rd, bus_addr, bus_wdata, m1_ack, m0_ack, w, a, d);
            end
            bus_rdy = (k == nwait + 1);
            bus_rdata = rv;
            tick;
        end
        if (!w) exp_rdata[m] = exp_err ? 32'h0 : rv;
        got  = mst(m);
        want = {1'b1, exp_err, exp_rdata[m]};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL done_owner m%0d nwait=%0d: got ack/err/rdata=%h want %h", m, nwait, got, want);
        end
        got  = mst(o);
        checks++;
        if ({got[33], got[31:0], bus_cs, bus_addr} !== {1'b0, exp_rdata[o], 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL done_other m%0d: got ack=%b rdata=%h cs=%b addr=%h want ack=0 rdata=%h cs=0 addr=0",
                     o, got[33], got[31:0], bus_cs, bus_addr, exp_rdata[o]);
        end
        bus_rdy = 1'b0;
        tick;
        req[m] = 1'b0;
        checks++;
        if ({m0_ack, m1_ack, bus_cs} !== 3'b000) begin
            errors++;
            $display("FAIL ack_pulse m%0d: got ack=%b%b cs=%b want 000", m, m1_ack, m0_ack, bus_cs);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 2'b11;
        wr  = 2'b11;
        addr[0] = 32'hA000_0000; wdata[0] = 32'h1111_1111;
        addr[1] = 32'hB000_0000; wdata[1] = 32'h2222_2222;
        bus_rdy = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (all_outs() !== 134'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %h want 0", i, all_outs());
            end
        end
        rst = 1'b0;
        favour_m = 0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        bus_rdy = 1'b0;
        tick;
        checks++;
        if ({bus_cs, bus_addr, bus_wdata} !== {1'b1, addr[0], wdata[0]}) begin
            errors++;
            $display("FAIL reset_first_grant: got cs=%b a=%h d=%h want cs=1 a=%h d=%h",
                     bus_cs, bus_addr, bus_wdata, addr[0], wdata[0]);
        end
        favour_m = 1;
        bus_rdy = 1'b1;
        req[1] = 1'b0;
        tick;
        checks++;
        if ({m0_ack, m0_err, m1_ack, m0_rdata} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL reset_first_ack: got ack0=%b err0=%b ack1=%b rd0=%h want 1 0 0 0",
                     m0_ack, m0_err, m1_ack, m0_rdata);
        end
        bus_rdy = 1'b0;
        tick;
        req = 2'b00;
    endtask

    task automatic test_single_read;
        run_xfer(0, 1'b0, 32'h0000_0100, $urandom, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_contention;
        int w;
        req = 2'b11;
        wr  = 2'b11;
        addr[0] = 32'h0000_1000;
        addr[1] = 32'h0000_2000;
        wdata[0] = $urandom;
        wdata[1] = $urandom;
        bus_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = favour_m;
            tick;
            checks++;
            if ({bus_cs, bus_wr_rd, bus_addr, bus_wdata} !== {2'b11, addr[w], wdata[w]}) begin
                errors++;
                $display("FAIL contention_bus #%0d: got cs=%b a=%h d=%h want m%0d a=%h d=%h",
                         i, bus_cs, bus_addr, bus_wdata, w, addr[w], wdata[w]);
            end
            tick;
            checks++;
            if ({(w == 1) ? m1_ack : m0_ack, (w == 1) ? m0_ack : m1_ack, mst(w) & 34'h0_FFFF_FFFF}
                !== {2'b10, 2'b00, exp_rdata[w]}) begin
                errors++;
                $display("FAIL contention_ack #%0d m%0d: got ack0=%b ack1=%b rdata=%h want owner ack only, rdata %h",
                         i, w, m0_ack, m1_ack, mst(w) & 34'h0_FFFF_FFFF, exp_rdata[w]);
            end
            favour_m = 1 - w;
            tick;
            wdata[w] = $urandom;
        end
        req = 2'b00;
        bus_rdy = 1'b0;
    endtask

    task automatic test_wait_timeout;
        run_xfer(1, 1'b0, 32'h0000_0200, $urandom, 32'h1234_5678, 3);
        run_xfer(1, 1'b0, 32'h0000_0204, $urandom, 32'hCAFE_F00D, TO + 5);
        run_xfer(1, 1'b0, 32'h0000_0208, $urandom, 32'h0BAD_CAFE, TO - 1);
        run_xfer(0, 1'b0, 32'h0000_020C, $urandom, 32'h5555_AAAA, TO);
    endtask

    task automatic test_reset_mid_access;
        req[0] = 1'b1;
        wr[0]  = 1'b0;
        addr[0] = 32'h0000_0300;
        bus_rdy = 1'b0;
        tick;
        tick;
        checks++;
        if (bus_cs !== 1'b1) begin
            errors++;
            $display("FAIL midrst_access: got cs=%b want 1", bus_cs);
        end
        rst = 1'b1;
        req[0] = 1'b0;
        tick;
        rst = 1'b0;
        favour_m = 0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        checks++;
        if (all_outs() !== 134'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0", all_outs());
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if ({m0_ack, bus_cs} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_no_ack cyc%0d: got ack0=%b cs=%b want 0 0", i, m0_ack, bus_cs);
            end
        end
        req = 2'b11;
        wr  = 2'b11;
        addr[0] = 32'h0000_0400;
        addr[1] = 32'h0000_0500;
        tick;
        checks++;
        if ({bus_cs, bus_addr} !== {1'b1, addr[0]}) begin
            errors++;
            $display("FAIL midrst_favour: got cs=%b a=%h want cs=1 a=%h", bus_cs, bus_addr, addr[0]);
        end
        favour_m = 1;
        bus_rdy = 1'b1;
        tick;
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_ack: got ack0=%b ack1=%b want 1 0", m0_ack, m1_ack);
        end
        bus_rdy = 1'b0;
        tick;
        req = 2'b00;
    endtask

    task automatic test_random;
        int m, nw, sel;
        for (int i = 0; i < 24; i++) begin
            m = $urandom_range(0, 1);
            sel = $urandom_range(0, 7);
            case (sel)
                5:       nw = TO - 1;
                6:       nw = TO;
                7:       nw = TO + 2;
                default: nw = $urandom_range(0, 4);
            endcase
            run_xfer(m, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, nw);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        wr  = 2'b00;
        addr[0] = 32'h0; addr[1] = 32'h0;
        wdata[0] = 32'h0; wdata[1] = 32'h0;
        bus_rdy = 1'b0;
        bus_rdata = 32'h0;
        favour_m = 0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        test_reset;
        test_single_read;
        test_contention;
        test_wait_timeout;
        test_reset_mid_access;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the external memory-mapped bus (CS / WR_RD / ADDR / write data / read data). It sits between the CPU's memory-stage bus port (master 0) and a second bus master, such as a DMA or debug loader (master 1), and hands the single external bus to one master at a time. Requests are granted round-robin. Each granted transfer runs as a single-beat access with a slave ready handshake and a timeout. The arbiter returns read data and a one-cycle acknowledge to the master that owned the transfer.

## Interface
Parameters:
- TIMEOUT, 15: number of ACCESS cycles without bus_rdy before a transfer is aborted with error. Legal range 1..255.

Ports:
- clk  in  1  system clock; single clock domain, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 transfer request; held high until m0_ack.
- m0_wr_rd  in  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_err  out  1  valid with m0_ack: 1 = transfer timed out.
- m0_rdata  out  32  master 0 read data; registered, held between transfers.
- m1_req, m1_wr_rd, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as the master 0 ports, for master 1.
- bus_cs  out  1  external chip select; high only in ACCESS.
- bus_wr_rd  out  1  external direction; 1 = write.
- bus_addr  out  32  external address.
- bus_wdata  out  32  external write data.
- bus_rdata  in  32  external read data.
- bus_rdy  in  1  slave ready; completes the access in the cycle it is high.

## Operation
- States: IDLE, ACCESS, DONE. Registered 2-bit state.
- IDLE: if any req is high, grant one master.
  - Latch that master's wr_rd, addr and wdata into bus registers.
  - Record the owner, clear the wait counter, and go to ACCESS.
  - If no req is high, stay in IDLE.
- Round-robin: a 1-bit favour pointer, reset to master 0.
  - On simultaneous requests the favoured master wins.
  - On every grant the pointer moves to the master that did not win.
  - A lone request is granted regardless of the pointer.
- ACCESS: bus_cs = 1, and bus_wr_rd/addr/wdata are driven from the latched values. They stay stable for the whole ACCESS.
  - bus_rdy high: complete the transfer and go to DONE. On a read, the owner's rdata is loaded from bus_rdata.
  - bus_rdy low: increment the wait counter. When the counter reaches TIMEOUT, go to DONE with error set; on a read, the owner's rdata is loaded with 0.
  - bus_rdy high in the same cycle the timeout would fire: rdy wins, err = 0.
- DONE: the owner's ack = 1 and err is valid. Requests are not sampled. Next state is IDLE.
- Outside ACCESS, bus_cs, bus_wr_rd, bus_addr and bus_wdata are all 0.
- The non-owning master's ack, err and rdata are unaffected by a transfer.
- Write completion leaves the owner's rdata unchanged.
- Master protocol: drop req in the cycle after ack unless a new transfer is wanted. Changing addr, wdata or wr_rd while req is pending and not yet granted is permitted. Changes after grant are ignored.
- rst, in any state: go to IDLE.
  - Favour pointer set to m0; counter and owner cleared.
  - Every output is 0: both ack, err and rdata, and all bus_* outputs.
  - An in-flight transfer is dropped with no ack.

## Timing
- req sampled high in IDLE in cycle t: bus_cs high in cycles t+1 onward.
- bus_rdy high in cycle t+1: ack in cycle t+2. Minimum latency is 2 cycles; the bus is busy for 3 cycles including IDLE.
- N wait cycles (rdy first high in cycle t+1+N, N < TIMEOUT): ack in cycle t+2+N.
- No rdy: ACCESS covers cycles t+1..t+TIMEOUT, ack with err = 1 in cycle t+TIMEOUT+1.
- Back-to-back transfers: the next grant is decided in the IDLE cycle after DONE, so the minimum spacing is 3 cycles per transfer.
- All outputs are registered; no combinational path from an input to any output.

## Test plan
- Reset: hold rst 2 cycles with both req high → all outputs 0 and no ack. Release → m0 is granted first, bus_cs rises 1 cycle later.
- Single read: m0 read at addr 0x0000_0100, bus_rdy held high, bus_rdata 0xDEAD_BEEF → bus_cs high for exactly 1 cycle with bus_addr 0x100. m0_ack 2 cycles after req, m0_rdata = 0xDEADBEEF, m0_err = 0.
- Contention: m0 and m1 request writes continuously → grants alternate m0, m1, m0, m1. Each ack arrives 3 cycles apart, and bus_wdata matches the owning master.
- Wait states and timeout: m1 read with rdy after 3 low cycles → ack at t+5, err = 0. Then rdy stuck low with TIMEOUT = 15 → ack at t+16, err = 1, m1_rdata = 0. Also check rdy rising on the 15th ACCESS cycle → err = 0.
- Reset mid-ACCESS: assert rst during the second wait cycle of an m0 read → next cycle bus_cs = 0, no m0_ack ever issued for that transfer, favour pointer back to m0.
